// File: rtl/fetch_decode_if.sv
// fetch_decode bus bundle: instruction fetch port,
// decoded controls, datapath feedback and data-memory handshake.
interface fetch_decode_if #(
    parameter int NBITS      = 8,
    parameter int NREGS      = 32,
    parameter int WIDTH_ALUF = 4
);
    localparam int RW = $clog2(NREGS);

    logic [NBITS-1:0]        IAddress;
    logic                    IReq;
    logic                    IAck;
    logic [31:0]             Instr;
    logic [RW-1:0]           RS1;
    logic [RW-1:0]           RS2;
    logic [RW-1:0]           RD;
    logic signed [NBITS-1:0] IMM;
    logic [WIDTH_ALUF-1:0]   ALUControl;
    logic                    ALUSrc;
    logic                    MemtoReg;
    logic                    RegWrite;
    logic                    link;
    logic [NBITS-1:0]        pclink;
    logic [NBITS-1:0]        PCReg;
    logic                    Zero;
    logic                    MemRead;
    logic                    MemWrite;
    logic                    DAck;
    logic                    Illegal;

    modport master (
        output IAddress, IReq, RS1, RS2, RD, IMM, ALUControl,
        output ALUSrc, MemtoReg, RegWrite, link, pclink,
        output MemRead, MemWrite, Illegal,
        input  IAck, Instr, PCReg, Zero, DAck
    );

    modport slave (
        input  IAddress, IReq, RS1, RS2, RD, IMM, ALUControl,
        input  ALUSrc, MemtoReg, RegWrite, link, pclink,
        input  MemRead, MemWrite, Illegal,
        output IAck, Instr, PCReg, Zero, DAck
    );
endinterface

// File: rtl/fetch_decode.sv
// Multi-cycle RV32I subset fetch/decode/control unit.
// Holds PC and IR, sequences FETCH/DECODE/EXEC/MEM/HALT.
module fetch_decode #(
    parameter int NBITS      = 8,
    parameter int NREGS      = 32,
    parameter int WIDTH_ALUF = 4
) (
    input logic            clock,
    input logic            reset,
    fetch_decode_if.master bus
);
    localparam int RW = $clog2(NREGS);
    localparam logic [WIDTH_ALUF-1:0] ALU_ADD = WIDTH_ALUF'(4'b0000);
    localparam logic [WIDTH_ALUF-1:0] ALU_XOR = WIDTH_ALUF'(4'b0100);
    localparam logic [WIDTH_ALUF-1:0] ALU_SUB = WIDTH_ALUF'(4'b1000);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [NBITS-1:0] r_pc;
    logic [31:0]      r_ir;
    logic [NBITS-1:0] w_pc_next;
    logic [NBITS-1:0] w_imm;
    logic [NBITS-1:0] w_pc4;

    logic [6:0] w_op;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic w_addi, w_xori, w_add, w_xor, w_beq;
    logic w_jal, w_jalr, w_lw, w_sw, w_alu, w_legal;
    logic w_fmt_i, w_fmt_s, w_fmt_b, w_fmt_j;

    assign w_op = r_ir[6:0];
    assign w_f3 = r_ir[14:12];
    assign w_f7 = r_ir[31:25];

    assign w_addi = (w_op == 7'b0010011) && (w_f3 == 3'b000);
    assign w_xori = (w_op == 7'b0010011) && (w_f3 == 3'b100);
    assign w_add  = (w_op == 7'b0110011) && (w_f7 == 7'd0)
                    && (w_f3 == 3'b000);
    assign w_xor  = (w_op == 7'b0110011) && (w_f7 == 7'd0)
                    && (w_f3 == 3'b100);
    assign w_beq  = (w_op == 7'b1100011) && (w_f3 == 3'b000);
    assign w_jal  = (w_op == 7'b1101111);
    assign w_jalr = (w_op == 7'b1100111) && (w_f3 == 3'b000);
    assign w_lw   = (w_op == 7'b0000011) && (w_f3 == 3'b010);
    assign w_sw   = (w_op == 7'b0100011) && (w_f3 == 3'b010);
    assign w_alu  = w_addi | w_xori | w_add | w_xor;
    assign w_legal = w_alu | w_beq | w_jal | w_jalr | w_lw | w_sw;

    assign w_fmt_i = (w_op == 7'b0010011) || (w_op == 7'b0000011)
                     || (w_op == 7'b1100111);
    assign w_fmt_s = (w_op == 7'b0100011);
    assign w_fmt_b = (w_op == 7'b1100011);
    assign w_fmt_j = (w_op == 7'b1101111);

    // Sign-extend the immediate per instruction format, then truncate.
    always_comb begin
        w_imm = '0;
        unique case (1'b1)
            w_fmt_i: w_imm = NBITS'({{20{r_ir[31]}}, r_ir[31:20]});
            w_fmt_s: w_imm = NBITS'({{20{r_ir[31]}}, r_ir[31:25],
                                     r_ir[11:7]});
            w_fmt_b: w_imm = NBITS'({{19{r_ir[31]}}, r_ir[31], r_ir[7],
                                     r_ir[30:25], r_ir[11:8], 1'b0});
            w_fmt_j: w_imm = NBITS'({{11{r_ir[31]}}, r_ir[31],
                                     r_ir[19:12], r_ir[20],
                                     r_ir[30:21], 1'b0});
            default: w_imm = '0;
        endcase
    end

    assign w_pc4          = r_pc + NBITS'(4);
    assign bus.IAddress   = r_pc;
    assign bus.pclink     = w_pc4;
    assign bus.IMM        = w_imm;
    assign bus.RS1        = r_ir[15 +: RW];
    assign bus.RS2        = r_ir[20 +: RW];
    assign bus.RD         = r_ir[7 +: RW];
    assign bus.ALUSrc     = w_addi | w_xori | w_jalr | w_lw | w_sw;

    // ALU function follows the decoded instruction.
    always_comb begin
        bus.ALUControl = ALU_ADD;
        unique case (1'b1)
            w_xori | w_xor: bus.ALUControl = ALU_XOR;
            w_beq:          bus.ALUControl = ALU_SUB;
            default:        bus.ALUControl = ALU_ADD;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_FETCH:  w_next = bus.IAck ? S_DECODE : S_FETCH;
            S_DECODE: w_next = w_legal ? S_EXEC : S_HALT;
            S_EXEC:   w_next = (w_lw | w_sw) ? S_MEM : S_FETCH;
            S_MEM:    w_next = bus.DAck ? S_FETCH : S_MEM;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    // State-dependent strobes; IReq held low while reset is asserted.
    always_comb begin
        bus.IReq     = 1'b0;
        bus.RegWrite = 1'b0;
        bus.link     = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.Illegal  = 1'b0;
        unique case (r_state)
            S_FETCH: bus.IReq = reset;
            S_EXEC: begin
                bus.RegWrite = w_alu | w_jal | w_jalr;
                bus.link     = w_jal | w_jalr;
            end
            S_MEM: begin
                bus.MemRead  = w_lw;
                bus.MemWrite = w_sw;
                bus.MemtoReg = w_lw & bus.DAck;
                bus.RegWrite = w_lw & bus.DAck;
            end
            S_HALT:  bus.Illegal = 1'b1;
            default: bus.IReq = 1'b0;
        endcase
    end

    // Next PC: commits at the end of EXEC or the DAck cycle.
    always_comb begin
        w_pc_next = r_pc;
        unique case (1'b1)
            (r_state == S_EXEC) && w_alu:
                w_pc_next = w_pc4;
            (r_state == S_EXEC) && w_beq:
                w_pc_next = bus.Zero ? (r_pc + w_imm) : w_pc4;
            (r_state == S_EXEC) && w_jal:
                w_pc_next = r_pc + w_imm;
            (r_state == S_EXEC) && w_jalr:
                w_pc_next = (bus.PCReg + w_imm) & ~NBITS'(1);
            (r_state == S_MEM) && bus.DAck:
                w_pc_next = w_pc4;
            default:
                w_pc_next = r_pc;
        endcase
    end

    // PC and instruction register; IR resets to a NOP.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc <= '0;
            r_ir <= 32'h0000_0013;
        end else begin
            r_pc <= w_pc_next;
            if ((r_state == S_FETCH) && bus.IAck) r_ir <= bus.Instr;
        end
    end
endmodule

// File: tb/tb_fetch_decode.sv
// Scoreboard bench for fetch_decode: directed instruction stream,
// expected fetch addresses / EXEC controls / MEM results queued.
module tb_fetch_decode;
    logic clock;
    logic reset;

    fetch_decode_if #(.NBITS(8), .NREGS(32), .WIDTH_ALUF(4)) bus ();

    fetch_decode #(.NBITS(8), .NREGS(32), .WIDTH_ALUF(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic       halt;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [7:0] imm;
        logic [3:0] aluc;
        logic       src;
        logic       rw;
        logic       lnk;
        logic [7:0] pcl;
    } exec_t;

    typedef struct packed {
        logic       rd;
        logic       wr;
        logic       m2r;
        logic       rw;
        logic [7:0] cyc;
    } mem_t;

    logic [7:0] q_fetch[$];
    exec_t      q_exec[$];
    mem_t       q_mem[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic exec_t ex(input logic [4:0] rs1,
                                 input logic [4:0] rs2,
                                 input logic [4:0] rd,
                                 input logic [7:0] imm,
                                 input logic [3:0] aluc,
                                 input logic src, input logic rw,
                                 input logic lnk,
                                 input logic [7:0] pcl);
        exec_t e;
        e.halt = 1'b0;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.imm = imm;
        e.aluc = aluc; e.src = src; e.rw = rw; e.lnk = lnk;
        e.pcl = pcl;
        return e;
    endfunction

    // Monitor: pop and compare whenever the DUT presents an event.
    int    cd = 0;
    int    scnt = 0;
    logic  at_exec;
    exec_t e_m;
    mem_t  m_m;
    always @(negedge clock) begin
        at_exec = 1'b0;
        if (!reset) begin
            cd = 0;
            scnt = 0;
        end else begin
            if (cd != 0) begin
                cd--;
                if (cd == 0) at_exec = 1'b1;
            end
            if (bus.IReq && bus.IAck) begin
                chk("fetch_q", 64'(q_fetch.size() != 0), 64'd1);
                if (q_fetch.size() != 0)
                    chk("IAddress", 64'(bus.IAddress),
                        64'(q_fetch.pop_front()));
                cd = 2;
            end
            if (at_exec) begin
                chk("exec_q", 64'(q_exec.size() != 0), 64'd1);
                if (q_exec.size() != 0) begin
                    e_m = q_exec.pop_front();
                    if (e_m.halt) begin
                        chk("halt_flags",
                            {61'd0, bus.Illegal, bus.IReq, bus.RegWrite},
                            64'b100);
                    end else begin
                        chk("exec_bundle",
                            64'({1'b0, bus.RS1, bus.RS2, bus.RD,
                                 8'(bus.IMM), bus.ALUControl,
                                 bus.ALUSrc, bus.RegWrite, bus.link,
                                 bus.pclink, bus.MemRead, bus.MemWrite,
                                 bus.Illegal}),
                            64'({e_m, 3'b000}));
                    end
                end
            end
            if (bus.MemRead || bus.MemWrite) scnt++;
            if (bus.DAck && (bus.MemRead || bus.MemWrite)) begin
                chk("mem_q", 64'(q_mem.size() != 0), 64'd1);
                if (q_mem.size() != 0) begin
                    m_m = q_mem.pop_front();
                    chk("mem_done",
                        64'({bus.MemRead, bus.MemWrite, bus.MemtoReg,
                             bus.RegWrite, 8'(scnt)}),
                        64'(m_m));
                end
                scnt = 0;
            end else if (!at_exec) begin
                chk("quiet_rw_link_m2r",
                    {61'd0, bus.RegWrite, bus.link, bus.MemtoReg}, 64'd0);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input int waitc,
                         input logic [7:0] addr, input exec_t e);
        int n;
        q_fetch.push_back(addr);
        q_exec.push_back(e);
        n = 0;
        while (!bus.IReq && n < 20) begin
            step();
            n++;
        end
        chk("ireq_seen", 64'(bus.IReq), 64'd1);
        repeat (waitc) step();
        bus.Instr = ins;
        bus.IAck  = 1'b1;
        step();
        bus.IAck  = 1'b0;
        bus.Instr = 32'hFFFF_FFFF;
    endtask

    task automatic mem_ack(input int dly, input mem_t m);
        int n;
        q_mem.push_back(m);
        n = 0;
        while (!(bus.MemRead || bus.MemWrite) && n < 10) begin
            step();
            n++;
        end
        chk("mem_strobe_seen", 64'(bus.MemRead | bus.MemWrite), 64'd1);
        repeat (dly) step();
        bus.DAck = 1'b1;
        step();
        bus.DAck = 1'b0;
    endtask

    task automatic chk_reset_state();
        chk("rst_IReq", 64'(bus.IReq), 64'd0);
        chk("rst_IAddress", 64'(bus.IAddress), 64'd0);
        chk("rst_fields", 64'({bus.RS1, bus.RS2, bus.RD, 8'(bus.IMM)}),
            64'd0);
        chk("rst_pclink", 64'(bus.pclink), 64'h04);
        chk("rst_aluc", 64'(bus.ALUControl), 64'h0);
        chk("rst_strobes",
            64'({bus.RegWrite, bus.MemRead, bus.MemWrite, bus.link,
                 bus.MemtoReg, bus.Illegal}), 64'd0);
    endtask

    exec_t e_halt;
    int    n_w;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        bus.IAck  = 1'b0;
        bus.Instr = 32'h0;
        bus.PCReg = 8'h00;
        bus.Zero  = 1'b0;
        bus.DAck  = 1'b0;
        e_halt    = '0;
        e_halt.halt = 1'b1;

        repeat (2) step();
        chk_reset_state();
        reset = 1'b1;

        issue(32'h00400093, 0, 8'h00,
              ex(5'd0, 5'd4, 5'd1, 8'h04, 4'h0, 1, 1, 0, 8'h04));
        issue(32'hFFF0C113, 2, 8'h04,
              ex(5'd1, 5'd31, 5'd2, 8'hFF, 4'h4, 1, 1, 0, 8'h08));
        issue(32'h002081B3, 0, 8'h08,
              ex(5'd1, 5'd2, 5'd3, 8'h00, 4'h0, 0, 1, 0, 8'h0C));
        issue(32'h0020C233, 0, 8'h0C,
              ex(5'd1, 5'd2, 5'd4, 8'h00, 4'h4, 0, 1, 0, 8'h10));
        bus.Zero = 1'b1;
        issue(32'hFE208CE3, 0, 8'h10,
              ex(5'd1, 5'd2, 5'd25, 8'hF8, 4'h8, 0, 0, 0, 8'h14));
        issue(32'h008002EF, 0, 8'h08,
              ex(5'd0, 5'd8, 5'd5, 8'h08, 4'h0, 0, 1, 1, 8'h0C));
        bus.Zero = 1'b0;
        issue(32'hFE208CE3, 0, 8'h10,
              ex(5'd1, 5'd2, 5'd25, 8'hF8, 4'h8, 0, 0, 0, 8'h14));
        issue(32'h0040A303, 0, 8'h14,
              ex(5'd1, 5'd4, 5'd6, 8'h04, 4'h0, 1, 0, 0, 8'h18));
        mem_ack(3, mem_t'({1'b1, 1'b0, 1'b1, 1'b1, 8'd4}));
        issue(32'h0020A423, 0, 8'h18,
              ex(5'd1, 5'd2, 5'd8, 8'h08, 4'h0, 1, 0, 0, 8'h1C));
        mem_ack(0, mem_t'({1'b0, 1'b1, 1'b0, 1'b0, 8'd1}));
        bus.PCReg = 8'h21;
        issue(32'h000083E7, 0, 8'h1C,
              ex(5'd1, 5'd0, 5'd7, 8'h00, 4'h0, 1, 1, 1, 8'h20));
        issue(32'h0DC0006F, 0, 8'h20,
              ex(5'd0, 5'd28, 5'd0, 8'hDC, 4'h0, 0, 1, 1, 8'h24));
        issue(32'h008002EF, 0, 8'hFC,
              ex(5'd0, 5'd8, 5'd5, 8'h08, 4'h0, 0, 1, 1, 8'h00));
        issue(32'h0040A303, 0, 8'h04,
              ex(5'd1, 5'd4, 5'd6, 8'h04, 4'h0, 1, 0, 0, 8'h08));

        n_w = 0;
        while (!bus.MemRead && n_w < 10) begin
            step();
            n_w++;
        end
        chk("lw_memread_before_rst", 64'(bus.MemRead), 64'd1);
        reset = 1'b0;
        #1;
        chk("rst_mid_mem_strobes",
            64'({bus.MemRead, bus.MemWrite, bus.RegWrite, bus.IReq}),
            64'd0);
        chk("rst_mid_mem_pc", 64'(bus.IAddress), 64'h00);
        @(negedge clock);
        step();
        reset = 1'b1;

        issue(32'hFFFF_FFFF, 0, 8'h00, e_halt);
        repeat (2) step();
        bus.IAck = 1'b1;
        repeat (6) begin
            step();
            chk("halt_ireq", 64'(bus.IReq), 64'd0);
            chk("halt_illegal", 64'(bus.Illegal), 64'd1);
        end
        bus.IAck = 1'b0;

        reset = 1'b0;
        #1;
        chk_reset_state();
        step();
        reset = 1'b1;
        @(negedge clock);
        chk("ireq_after_release", 64'(bus.IReq), 64'd1);
        chk("iaddr_after_release", 64'(bus.IAddress), 64'd0);
        step();

        chk("q_fetch_left", 64'(q_fetch.size()), 64'd0);
        chk("q_exec_left", 64'(q_exec.size()), 64'd0);
        chk("q_mem_left", 64'(q_mem.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
